// File: rtl/regfile_write_queue_pkg.sv
// Shared types for the register file write-back path.
// Optional feature macro: R0_DISCARD_EN (writes to and lookups of register 0 are dropped).
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

`ifdef R0_DISCARD_EN
    localparam bit R0_DISCARD = 1'b1;
`else
    localparam bit R0_DISCARD = 1'b0;
`endif

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_A,
        SRC_B
    } wb_src_e;

    // Register 0 is hard-wired to zero when the discard option is built in.
    function automatic logic isDiscarded(input logic [REG_ADDR_W-1:0] addr);
        return R0_DISCARD && (addr == '0);
    endfunction

endpackage

// File: rtl/regfile_write_queue_if.sv
// Write-request, register-file write port and forwarding lookup signals of regfile_write_queue.
interface regfile_write_queue_if;
    import regfile_pkg::*;

    logic                  aValid;
    logic                  aReady;
    logic [REG_ADDR_W-1:0] aAddr;
    logic [REG_DATA_W-1:0] aData;
    logic                  bValid;
    logic                  bReady;
    logic [REG_ADDR_W-1:0] bAddr;
    logic [REG_DATA_W-1:0] bData;
    logic                  rfWe;
    logic [REG_ADDR_W-1:0] rfWaddr;
    logic [REG_DATA_W-1:0] rfWdata;
    logic [REG_ADDR_W-1:0] lkAddr;
    logic                  lkHit;
    logic [REG_DATA_W-1:0] lkData;

    modport master (
        output aValid, aAddr, aData, bValid, bAddr, bData, lkAddr,
        input  aReady, bReady, rfWe, rfWaddr, rfWdata, lkHit, lkData
    );

    modport slave (
        input  aValid, aAddr, aData, bValid, bAddr, bData, lkAddr,
        output aReady, bReady, rfWe, rfWaddr, rfWdata, lkHit, lkData
    );

endinterface

// File: rtl/regfile_write_queue_wb_fifo.sv
// In-order write-back queue; entries are presented oldest-first so the lookup can pick the youngest match.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_entry_t             pushEntry,
    input  logic                  pop,
    output logic [CNT_W-1:0]      count,
    output wb_entry_t [DEPTH-1:0] entries,
    output logic [DEPTH-1:0]      entryValid
);

    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    wb_entry_t        mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= pushEntry;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        entries    = '0;
        entryValid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries[i]    = mem[rdPtr + PTR_W'(i)];
            entryValid[i] = CNT_W'(i) < count;
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// Two-source write-back arbiter and queue feeding the register file write port, with pending-write lookup.
// Optional feature macro: R0_DISCARD_EN (see regfile_pkg).
module regfile_write_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    regfile_write_queue_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]      count;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      entryValid;
    logic                  notFull;
    wb_src_e               src;
    wb_entry_t             acceptEntry;
    logic                  push;
    logic                  pop;

    // Ready deliberately ignores the pop happening this cycle.
    assign notFull    = count < CNT_W'(DEPTH);
    assign bus.aReady = notFull;
    assign bus.bReady = notFull && !bus.aValid;

    always_comb begin
        src         = SRC_NONE;
        acceptEntry = '{addr: bus.aAddr, data: bus.aData};
        if (bus.aValid && notFull) begin
            src = SRC_A;
        end else if (bus.bValid && notFull) begin
            src         = SRC_B;
            acceptEntry = '{addr: bus.bAddr, data: bus.bData};
        end
    end

    assign push = (src != SRC_NONE) && !isDiscarded(acceptEntry.addr);
    assign pop  = count != '0;

    wb_fifo #(.DEPTH(DEPTH)) fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pushEntry (acceptEntry),
        .pop       (pop),
        .count     (count),
        .entries   (entries),
        .entryValid(entryValid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rfWe    <= 1'b0;
            bus.rfWaddr <= '0;
            bus.rfWdata <= '0;
        end else if (pop) begin
            bus.rfWe    <= 1'b1;
            bus.rfWaddr <= entries[0].addr;
            bus.rfWdata <= entries[0].data;
        end else begin
            bus.rfWe <= 1'b0;
        end
    end

    // Scan oldest to youngest so the last match (youngest) overrides.
    always_comb begin
        bus.lkHit  = 1'b0;
        bus.lkData = '0;
        if (bus.rfWe && (bus.rfWaddr == bus.lkAddr)) begin
            bus.lkHit  = 1'b1;
            bus.lkData = bus.rfWdata;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i] && (entries[i].addr == bus.lkAddr)) begin
                bus.lkHit  = 1'b1;
                bus.lkData = entries[i].data;
            end
        end
        if (isDiscarded(bus.lkAddr)) begin
            bus.lkHit  = 1'b0;
            bus.lkData = '0;
        end
    end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Scenario tests for regfile_write_queue with a commit-order scoreboard.
module tb_regfile_write_queue;
    import regfile_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    wb_entry_t expQ[$];
    wb_entry_t expEntry;

    regfile_write_queue_if bus();

    regfile_write_queue #(.DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepted requests are pushed as expected commits; every rf write pops one.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rfWe) begin
                vectors++;
                if (expQ.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL commit_unexpected: got write addr=%0d data=%h, expected no write", bus.rfWaddr, bus.rfWdata);
                end else begin
                    expEntry = expQ.pop_front();
                    if (bus.rfWaddr !== expEntry.addr || bus.rfWdata !== expEntry.data) begin
                        miscompares++;
                        $display("[TB] FAIL commit_order: got addr=%0d data=%h, expected addr=%0d data=%h", bus.rfWaddr, bus.rfWdata, expEntry.addr, expEntry.data);
                    end
                end
            end
            if (bus.aValid && bus.aReady) begin
                if (!(R0_DISCARD && bus.aAddr == 5'd0)) expQ.push_back('{addr: bus.aAddr, data: bus.aData});
            end else if (bus.bValid && bus.bReady) begin
                if (!(R0_DISCARD && bus.bAddr == 5'd0)) expQ.push_back('{addr: bus.bAddr, data: bus.bData});
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.aValid = 1'b0; bus.aAddr = '0; bus.aData = '0;
        bus.bValid = 1'b0; bus.bAddr = '0; bus.bData = '0;
        bus.lkAddr = '0;
        @(posedge clk); #1;
        vectors++;
        if (bus.rfWe !== 1'b0 || bus.rfWaddr !== 5'd0 || bus.rfWdata !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_rf: got we=%b addr=%0d data=%h, expected 0/0/0", bus.rfWe, bus.rfWaddr, bus.rfWdata);
        end
        vectors++;
        if (bus.lkHit !== 1'b0 || bus.lkData !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_lookup: got hit=%b data=%h, expected 0/0", bus.lkHit, bus.lkData);
        end
        vectors++;
        if (bus.aReady !== 1'b1 || bus.bReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got a=%b b=%b, expected 1/1", bus.aReady, bus.bReady);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        @(posedge clk); #1;
        bus.aValid = 1'b1; bus.aAddr = 5'd3; bus.aData = 32'hDEADBEEF; bus.lkAddr = 5'd3;
        @(negedge clk);
        vectors++;
        if (bus.aReady !== 1'b1 || bus.lkHit !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_present: got ready=%b hit=%b, expected 1/0", bus.aReady, bus.lkHit);
        end
        @(posedge clk); #1;
        bus.aValid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.rfWe !== 1'b0 || bus.lkHit !== 1'b1 || bus.lkData !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL single_queued: got we=%b hit=%b data=%h, expected 0/1/deadbeef", bus.rfWe, bus.lkHit, bus.lkData);
        end
        @(negedge clk);
        vectors++;
        if (bus.rfWe !== 1'b1 || bus.rfWaddr !== 5'd3 || bus.rfWdata !== 32'hDEADBEEF || bus.lkHit !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_output: got we=%b addr=%0d data=%h hit=%b, expected 1/3/deadbeef/1", bus.rfWe, bus.rfWaddr, bus.rfWdata, bus.lkHit);
        end
        @(negedge clk);
        vectors++;
        if (bus.rfWe !== 1'b0 || bus.lkHit !== 1'b0 || bus.lkData !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL single_done: got we=%b hit=%b data=%h, expected 0/0/0", bus.rfWe, bus.lkHit, bus.lkData);
        end
    endtask

    task automatic test_priority();
        @(posedge clk); #1;
        bus.bValid = 1'b1; bus.bAddr = 5'd20; bus.bData = 32'hB0B0_0020;
        for (int c = 0; c < 3; c++) begin
            bus.aValid = 1'b1; bus.aAddr = 5'(10 + c); bus.aData = 32'hA000_0000 + 32'(c);
            @(negedge clk);
            vectors++;
            if (bus.aReady !== 1'b1 || bus.bReady !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL prio_both_valid: got a=%b b=%b, expected 1/0", bus.aReady, bus.bReady);
            end
            @(posedge clk); #1;
        end
        bus.aValid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.bReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL prio_b_alone: got b=%b, expected 1", bus.bReady);
        end
        @(posedge clk); #1;
        bus.bValid = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        for (int c = 0; c < 9; c++) begin
            bus.aValid = (c < 6);
            bus.aAddr  = 5'(c + 1);
            bus.aData  = $urandom;
            @(negedge clk);
            if (c < 6) begin
                vectors++;
                if (bus.aReady !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL burst_ready[%0d]: got %b, expected 1", c, bus.aReady);
                end
            end
            vectors++;
            if (bus.rfWe !== ((c >= 2) && (c < 8))) begin
                miscompares++;
                $display("[TB] FAIL burst_we[%0d]: got %b, expected %b", c, bus.rfWe, (c >= 2) && (c < 8));
            end
            @(posedge clk); #1;
        end
        bus.aValid = 1'b0;
    endtask

    task automatic test_same_addr();
        @(posedge clk); #1;
        bus.aValid = 1'b1; bus.aAddr = 5'd5; bus.aData = 32'h11; bus.lkAddr = 5'd5;
        @(negedge clk);
        vectors++;
        if (bus.lkHit !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL same_before: got hit=%b, expected 0", bus.lkHit);
        end
        @(posedge clk); #1;
        bus.aData = 32'h22;
        @(negedge clk);
        vectors++;
        if (bus.lkHit !== 1'b1 || bus.lkData !== 32'h11) begin
            miscompares++;
            $display("[TB] FAIL same_first: got hit=%b data=%h, expected 1/11", bus.lkHit, bus.lkData);
        end
        @(posedge clk); #1;
        bus.aValid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.lkHit !== 1'b1 || bus.lkData !== 32'h22 || bus.rfWdata !== 32'h11) begin
            miscompares++;
            $display("[TB] FAIL same_youngest: got hit=%b data=%h rf=%h, expected 1/22/11", bus.lkHit, bus.lkData, bus.rfWdata);
        end
        @(negedge clk);
        vectors++;
        if (bus.lkHit !== 1'b1 || bus.lkData !== 32'h22 || bus.rfWdata !== 32'h22) begin
            miscompares++;
            $display("[TB] FAIL same_second: got hit=%b data=%h rf=%h, expected 1/22/22", bus.lkHit, bus.lkData, bus.rfWdata);
        end
        @(negedge clk);
        vectors++;
        if (bus.lkHit !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL same_done: got hit=%b, expected 0", bus.lkHit);
        end
    endtask

    task automatic test_reset_mid_drain();
        bus.lkAddr = 5'd9;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            bus.aValid = 1'b1; bus.aAddr = 5'(7 + c); bus.aData = 32'hC0DE_0000 + 32'(c);
            @(posedge clk); #1;
        end
        // Writes 8 (in the output register) and 9 (queued) must be dropped.
        bus.aValid = 1'b0;
        rst = 1'b1;
        expQ.delete();
        #1;
        vectors++;
        if (bus.rfWe !== 1'b0 || bus.rfWaddr !== 5'd0 || bus.rfWdata !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL drain_reset_rf: got we=%b addr=%0d data=%h, expected 0/0/0", bus.rfWe, bus.rfWaddr, bus.rfWdata);
        end
        vectors++;
        if (bus.lkHit !== 1'b0 || bus.aReady !== 1'b1 || bus.bReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL drain_reset_state: got hit=%b a=%b b=%b, expected 0/1/1", bus.lkHit, bus.aReady, bus.bReady);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.rfWe !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL drain_after[%0d]: got we=%b addr=%0d, expected no write", c, bus.rfWe, bus.rfWaddr);
            end
        end
    endtask

    task automatic test_r0();
        bus.lkAddr = 5'd0;
        @(posedge clk); #1;
        bus.aValid = 1'b1; bus.aAddr = 5'd0; bus.aData = 32'hFFFFFFFF;
        @(negedge clk);
        vectors++;
        if (bus.aReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL r0_ready: got %b, expected 1", bus.aReady);
        end
        @(posedge clk); #1;
        bus.aValid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.lkHit !== !R0_DISCARD || bus.lkData !== (R0_DISCARD ? 32'd0 : 32'hFFFFFFFF)) begin
            miscompares++;
            $display("[TB] FAIL r0_lookup: got hit=%b data=%h, expected %b", bus.lkHit, bus.lkData, !R0_DISCARD);
        end
        @(negedge clk);
        vectors++;
        if (bus.rfWe !== !R0_DISCARD || (!R0_DISCARD && (bus.rfWaddr !== 5'd0 || bus.rfWdata !== 32'hFFFFFFFF))) begin
            miscompares++;
            $display("[TB] FAIL r0_commit: got we=%b addr=%0d data=%h, expected we=%b", bus.rfWe, bus.rfWaddr, bus.rfWdata, !R0_DISCARD);
        end
        @(negedge clk);
        vectors++;
        if (bus.rfWe !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL r0_idle: got we=%b, expected 0", bus.rfWe);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_write();
        test_priority();
        test_back_to_back();
        test_same_addr();
        test_reset_mid_drain();
        test_r0();
        repeat (4) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d outstanding writes, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
